mig_decouple_gate: RTL and testbench
====================================

Name: mig_decouple_gate

Overview:
- Parametrised migration gate on the AXI-Stream path between the NIC datapath and the reconfigurable partition.
- Sequences a live migration: quiesces traffic at a packet boundary, asserts decouple, then holds or drops inbound packets per source port. Releases on migration_ready.
- Generalised over data width, tuser width, port count and decouple width, with per-port selective drop and a drop counter.

Parameters:
AXIS_DATA_WIDTH, 512, tdata width; tkeep is AXIS_DATA_WIDTH/8
AXIS_TUSER_WIDTH, 256, tuser width
NUM_PORTS, 8, source-port bitmap width
SRC_PORT_LSB, 16, LSB of one-hot source-port field in tuser
DECOUPLE_WIDTH, 4, decouple bus width; all bits driven identically
CNT_WIDTH, 32, drop counter width

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  upstream stream
s_axis_tready  out  1  upstream ready
m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per params  stream to partition
m_axis_tready  in  1  partition ready
migration_start  in  1  single-cycle request
migration_ready  in  1  level; reconfiguration/state load done
buffering_type  in  2  00 stall all, 01 drop matching/stall rest, 11 drop all, 10 = stall
buffering_port  in  NUM_PORTS  port mask for type 01
migration_progress  out  1  high from accept of start until return to IDLE
decouple  out  DECOUPLE_WIDTH  partition isolation
drop_count  out  CNT_WIDTH  saturating dropped-packet count
drop_count_clr  in  1  synchronous clear

Behaviour:
- Reset (async, any state): state=IDLE, in_pkt=0, drop_pkt=0, migration_progress=0, decouple=0, drop_count=0. Combinational outputs follow the IDLE rules.
- in_pkt: set on an accepted beat (s_tvalid&&s_tready) with !tlast. Cleared on an accepted tlast beat.
- Start-of-packet (SOP) = accepted beat while in_pkt==0.
- IDLE:
  - Zero-latency pass-through: m_* = s_*, s_tready = m_tready.
  - migration_start -> DRAIN, progress=1 next cycle.
- DRAIN:
  - Current packet continues to pass through.
  - New SOPs are blocked: while in_pkt==0, s_tready=0 and m_tvalid=0.
  - When in_pkt==0 (registered), -> HOLD; decouple=all-ones next cycle.
  - A DRAIN entered between packets reaches HOLD one cycle after entry.
- HOLD:
  - m_tvalid=0; m_tdata/tkeep/tuser/tlast don't-care.
  - At an SOP candidate (s_tvalid, in_pkt==0), compute match = |(s_tuser[SRC_PORT_LSB +: NUM_PORTS] & buffering_port).
  - Drop decision: type 11 -> drop; type 01 && match -> drop; otherwise stall (s_tready=0).
  - While dropping, s_tready=1. drop_pkt is latched at SOP and held until the accepted tlast; mid-packet beats bypass the re-evaluation.
  - drop_count increments once per dropped packet, at SOP; it saturates at all-ones.
  - buffering_type/port changes take effect only at the next SOP.
- Exit HOLD: migration_ready=1 -> RESUME; decouple=0 next cycle.
- RESUME:
  - If drop_pkt=1, continue discarding until tlast (s_tready=1, m_tvalid=0); new SOPs are stalled.
  - When drop_pkt==0 -> IDLE, progress=0.
- migration_start outside IDLE: ignored.
- migration_ready outside HOLD: ignored.
- drop_count_clr with a simultaneous increment: clear wins (count=0).
- A single-beat packet (SOP with tlast) dropped in HOLD: counted, drop_pkt stays 0.
- No internal data storage; all data-path latency is 0 cycles.

Test Plan:
- IDLE pass-through: 3-beat packet, m_tready toggling -> identical beats/tkeep/tuser on m_*, count=0, decouple=0.
- Start mid-packet: migration_start at beat 2 of 5 -> beats 3-5 forwarded; next packet stalled; decouple=4'hF one cycle after tlast; progress=1.
- Selective drop: type 01, port mask 8'h04; packets from tuser[23:16]=8'h04 (2 pkts, 4 beats each) -> s_tready=1, m_tvalid=0, drop_count=2; then 8'h01 packet -> s_tready=0 stall.
- Resume mid-drop: migration_ready asserted at beat 2 of 4 of a dropped packet -> decouple=0 next cycle; remaining beats discarded; IDLE after tlast; stalled 8'h01 packet then forwarded intact.
- Saturation/clear: CNT_WIDTH=2, type 11, 5 packets -> drop_count=3. Clear coincident with a 6th SOP -> count=0.
- Async reset in HOLD with drop_pkt=1 -> immediately decouple=0, progress=0, count=0, pass-through restored.

Source files
------------

// File: rtl/mig_decouple_gate.sv
// AXI-Stream migration gate between the NIC datapath and a reconfigurable partition.
// Quiesces at a packet boundary, decouples, then holds or drops inbound packets until released.
module mig_decouple_gate #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 256,
   parameter int NUM_PORTS        = 8,
   parameter int SRC_PORT_LSB     = 16,
   parameter int DECOUPLE_WIDTH   = 4,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                          axis_aclk,
   input  logic                          axis_resetn,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   input  logic                          migration_start,
   input  logic                          migration_ready,
   input  logic [1:0]                    buffering_type,
   input  logic [NUM_PORTS-1:0]          buffering_port,
   output logic                          migration_progress,
   output logic [DECOUPLE_WIDTH-1:0]     decouple,
   output logic [CNT_WIDTH-1:0]          drop_count,
   input  logic                          drop_count_clr
);

   typedef enum logic [1:0] {IDLE, DRAIN, HOLD, RESUME} state_t;

   state_t state, state_nxt;
   logic   in_pkt;
   logic   drop_pkt;
   logic   pass;
   logic   drop_rdy;
   logic   drop_sel;
   logic   accept;
   logic   sop_drop;

   assign drop_sel = (buffering_type == 2'b11) ||
                     ((buffering_type == 2'b01) &&
                      (|(s_axis_tuser[SRC_PORT_LSB +: NUM_PORTS] & buffering_port)));

   // In HOLD the only packets ever accepted are dropped ones, so a mid-packet
   // beat there always belongs to a latched drop.
   always_comb begin
      state_nxt = state;
      pass      = 1'b0;
      drop_rdy  = 1'b0;
      case (state)
         IDLE: begin
            pass = 1'b1;
            if (migration_start) state_nxt = DRAIN;
         end
         DRAIN: begin
            pass = in_pkt;
            if (!in_pkt) state_nxt = HOLD;
         end
         HOLD: begin
            drop_rdy = in_pkt ? drop_pkt : drop_sel;
            if (migration_ready) state_nxt = RESUME;
         end
         RESUME: begin
            drop_rdy = drop_pkt;
            if (!drop_pkt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = s_axis_tvalid && pass;
   assign s_axis_tready = pass ? m_axis_tready : drop_rdy;

   assign accept   = s_axis_tvalid && s_axis_tready;
   assign sop_drop = accept && (state == HOLD) && !in_pkt;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state              <= IDLE;
         in_pkt             <= 1'b0;
         drop_pkt           <= 1'b0;
         migration_progress <= 1'b0;
         decouple           <= '0;
         drop_count         <= '0;
      end else begin
         state <= state_nxt;
         if (accept) in_pkt <= !s_axis_tlast;

         if (sop_drop)
            drop_pkt <= !s_axis_tlast;
         else if (accept && s_axis_tlast)
            drop_pkt <= 1'b0;

         if ((state == IDLE) && migration_start)
            migration_progress <= 1'b1;
         else if ((state == RESUME) && !drop_pkt)
            migration_progress <= 1'b0;

         if ((state == DRAIN) && !in_pkt)
            decouple <= {DECOUPLE_WIDTH{1'b1}};
         else if ((state == HOLD) && migration_ready)
            decouple <= '0;

         // Clear has priority over a coincident increment; the count sticks at all-ones.
         if (drop_count_clr)
            drop_count <= '0;
         else if (sop_drop && (drop_count != {CNT_WIDTH{1'b1}}))
            drop_count <= drop_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_mig_decouple_gate.sv
// Scoreboard bench for mig_decouple_gate: random packets, expected beats queued, monitor compares.
module tb_mig_decouple_gate;

   localparam int DW  = 32;
   localparam int KW  = DW/8;
   localparam int UW  = 32;
   localparam int NP  = 8;
   localparam int LSB = 16;
   localparam int DCW = 4;
   localparam int CW  = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic           axis_aclk = 1'b0;
   logic           axis_resetn;
   logic [DW-1:0]  s_axis_tdata;
   logic [KW-1:0]  s_axis_tkeep;
   logic [UW-1:0]  s_axis_tuser;
   logic           s_axis_tvalid;
   logic           s_axis_tlast;
   logic           s_axis_tready;
   logic [DW-1:0]  m_axis_tdata;
   logic [KW-1:0]  m_axis_tkeep;
   logic [UW-1:0]  m_axis_tuser;
   logic           m_axis_tvalid;
   logic           m_axis_tlast;
   logic           m_axis_tready;
   logic           migration_start;
   logic           migration_ready;
   logic [1:0]     buffering_type;
   logic [NP-1:0]  buffering_port;
   logic           migration_progress;
   logic [DCW-1:0] decouple;
   logic [CW-1:0]  drop_count;
   logic           drop_count_clr;

   int    n_cmp = 0;
   int    n_err = 0;
   int    exp_cnt = 0;
   bit    rand_ready = 0;
   beat_t exp_q[$];

   mig_decouple_gate #(
      .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .NUM_PORTS(NP),
      .SRC_PORT_LSB(LSB), .DECOUPLE_WIDTH(DCW), .CNT_WIDTH(CW)
   ) dut (
      .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .migration_start(migration_start), .migration_ready(migration_ready),
      .buffering_type(buffering_type), .buffering_port(buffering_port),
      .migration_progress(migration_progress), .decouple(decouple),
      .drop_count(drop_count), .drop_count_clr(drop_count_clr)
   );

   always #5 axis_aclk = ~axis_aclk;

   // Partition back-pressure: random when enabled, otherwise always ready.
   initial begin
      forever begin
         @(posedge axis_aclk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every beat the partition takes must be the next expected one.
   always @(negedge axis_aclk) begin
      if (axis_resetn && m_axis_tvalid && m_axis_tready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected_beat: got data %0h user %0h, expected no beat",
                     m_axis_tdata, m_axis_tuser);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k ||
                m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
               n_err++;
               $display("[TB] FAIL beat: got %0h/%0h/%0h/%0b, expected %0h/%0h/%0h/%0b",
                        m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
                        e.d, e.k, e.u, e.l);
            end
         end
      end
   end

   function automatic beat_t makeBeat(input logic [NP-1:0] src, input logic last);
      beat_t b;
      b.d = $urandom;
      b.k = KW'($urandom);
      b.u = $urandom;
      b.u[LSB +: NP] = src;
      b.l = last;
      return b;
   endfunction

   function automatic bit predictDrop(input logic [1:0] t, input logic [NP-1:0] mask,
                                      input logic [NP-1:0] src);
      if (t == 2'b11) return 1;
      if (t == 2'b01 && (src & mask) != 0) return 1;
      return 0;
   endfunction

   function automatic int satInc(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Called just after a rising edge; single-cycle control pulses are dropped after the first edge.
   task automatic applyStimulus(input beat_t b, input int max_wait, output bit ok, output int cyc);
      bit hs;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tuser  = b.u;
      s_axis_tlast  = b.l;
      s_axis_tvalid = 1'b1;
      ok  = 0;
      cyc = 0;
      for (int i = 0; i < max_wait; i++) begin
         @(negedge axis_aclk);
         hs = s_axis_tready;
         @(posedge axis_aclk);
         #1;
         migration_start = 1'b0;
         migration_ready = 1'b0;
         drop_count_clr  = 1'b0;
         cyc++;
         if (hs) begin
            ok = 1;
            break;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic sendPkt(input logic [NP-1:0] src, input int nb, input bit fwd);
      beat_t b;
      bit    ok;
      int    cyc;
      for (int i = 0; i < nb; i++) begin
         b = makeBeat(src, (i == nb - 1));
         if (fwd) exp_q.push_back(b);
         applyStimulus(b, fwd ? 60 : 1, ok, cyc);
         checkOutput(fwd ? "fwd_accept" : "drop_accept", ok, 1);
      end
   endtask

   task automatic expectStall(input logic [NP-1:0] src);
      beat_t b;
      b = makeBeat(src, 1'b0);
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tuser  = b.u;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge axis_aclk);
         checkOutput("stall_tready", s_axis_tready, 0);
         checkOutput("stall_tvalid", m_axis_tvalid, 0);
      end
      @(posedge axis_aclk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic waitEmpty();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge axis_aclk);
         #1;
         n++;
      end
      checkOutput("drain_queue", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      beat_t b;
      bit    ok;
      int    cyc;
      logic [1:0]    t;
      logic [NP-1:0] mask;
      logic [NP-1:0] src;
      int            nb;

      axis_resetn     = 1'b0;
      s_axis_tdata    = '0;
      s_axis_tkeep    = '0;
      s_axis_tuser    = '0;
      s_axis_tvalid   = 1'b0;
      s_axis_tlast    = 1'b0;
      m_axis_tready   = 1'b1;
      migration_start = 1'b0;
      migration_ready = 1'b0;
      buffering_type  = 2'b00;
      buffering_port  = '0;
      drop_count_clr  = 1'b0;
      #23;
      checkOutput("rst_decouple", decouple, 0);
      checkOutput("rst_progress", migration_progress, 0);
      checkOutput("rst_count", drop_count, 0);
      checkOutput("rst_tready", s_axis_tready, 1);
      axis_resetn = 1'b1;
      @(posedge axis_aclk);
      #1;

      $display("[TB] IDLE pass-through");
      rand_ready = 1;
      for (int p = 0; p < 3; p++) sendPkt(NP'(1) << $urandom_range(0, NP-1), 3, 1);
      waitEmpty();
      checkOutput("idle_count", drop_count, 0);
      checkOutput("idle_decouple", decouple, 0);

      $display("[TB] start mid-packet");
      for (int i = 0; i < 5; i++) begin
         b = makeBeat(8'h02, (i == 4));
         exp_q.push_back(b);
         if (i == 2) migration_start = 1'b1;
         applyStimulus(b, 60, ok, cyc);
         checkOutput("drain_fwd_accept", ok, 1);
      end
      checkOutput("drain_progress", migration_progress, 1);
      @(posedge axis_aclk);
      #1;
      checkOutput("hold_decouple", decouple, 4'hF);
      waitEmpty();
      expectStall(8'h01);
      rand_ready = 0;

      $display("[TB] selective drop");
      buffering_type = 2'b01;
      buffering_port = 8'h04;
      for (int p = 0; p < 2; p++) begin
         sendPkt(8'h04, 4, 0);
         exp_cnt = satInc(exp_cnt);
      end
      checkOutput("sel_count", drop_count, exp_cnt);
      expectStall(8'h01);

      for (int p = 0; p < 10; p++) begin
         t    = 2'($urandom_range(0, 3));
         mask = NP'($urandom);
         src  = NP'(1) << $urandom_range(0, NP-1);
         nb   = $urandom_range(1, 4);
         buffering_type = t;
         buffering_port = mask;
         if (predictDrop(t, mask, src)) begin
            sendPkt(src, nb, 0);
            exp_cnt = satInc(exp_cnt);
         end else begin
            expectStall(src);
         end
      end
      checkOutput("rand_count", drop_count, exp_cnt);
      checkOutput("rand_decouple", decouple, 4'hF);

      $display("[TB] resume mid-drop");
      buffering_type = 2'b01;
      buffering_port = 8'h04;
      for (int i = 0; i < 4; i++) begin
         b = makeBeat(8'h04, (i == 3));
         if (i == 2) migration_ready = 1'b1;
         applyStimulus(b, 1, ok, cyc);
         checkOutput("resume_drop_accept", ok, 1);
         if (i == 2) checkOutput("resume_decouple", decouple, 0);
      end
      exp_cnt = satInc(exp_cnt);
      b = makeBeat(8'h01, 1'b0);
      exp_q.push_back(b);
      applyStimulus(b, 20, ok, cyc);
      checkOutput("resume_stall_cycles", cyc, 2);
      for (int i = 1; i < 3; i++) begin
         b = makeBeat(8'h01, (i == 2));
         exp_q.push_back(b);
         applyStimulus(b, 20, ok, cyc);
         checkOutput("resume_fwd_accept", ok, 1);
      end
      waitEmpty();
      checkOutput("resume_progress", migration_progress, 0);
      checkOutput("resume_count", drop_count, exp_cnt);

      $display("[TB] saturation and clear");
      drop_count_clr = 1'b1;
      @(posedge axis_aclk);
      #1;
      drop_count_clr = 1'b0;
      exp_cnt = 0;
      checkOutput("clr_count", drop_count, 0);
      migration_start = 1'b1;
      @(posedge axis_aclk);
      #1;
      migration_start = 1'b0;
      checkOutput("sat_progress", migration_progress, 1);
      checkOutput("sat_decouple_early", decouple, 0);
      @(posedge axis_aclk);
      #1;
      checkOutput("sat_decouple", decouple, 4'hF);
      buffering_type = 2'b11;
      for (int p = 0; p < 5; p++) begin
         sendPkt(NP'(1) << $urandom_range(0, NP-1), (p == 0 || p == 2) ? 1 : 2, 0);
         exp_cnt = satInc(exp_cnt);
      end
      checkOutput("sat_count", drop_count, exp_cnt);
      drop_count_clr = 1'b1;
      sendPkt(8'h10, 3, 0);
      exp_cnt = 0;
      checkOutput("clr_wins_count", drop_count, exp_cnt);
      sendPkt(8'h20, 1, 0);
      exp_cnt = satInc(exp_cnt);
      b = makeBeat(8'h40, 1'b0);
      applyStimulus(b, 1, ok, cyc);
      checkOutput("pre_rst_accept", ok, 1);
      exp_cnt = satInc(exp_cnt);
      checkOutput("pre_rst_count", drop_count, exp_cnt);

      $display("[TB] async reset in HOLD");
      #2;
      axis_resetn = 1'b0;
      #1;
      checkOutput("arst_decouple", decouple, 0);
      checkOutput("arst_progress", migration_progress, 0);
      checkOutput("arst_count", drop_count, 0);
      checkOutput("arst_tready", s_axis_tready, m_axis_tready);
      exp_cnt = 0;
      #3;
      axis_resetn = 1'b1;
      @(posedge axis_aclk);
      #1;
      sendPkt(8'h80, 3, 1);
      waitEmpty();
      checkOutput("post_rst_decouple", decouple, 0);
      checkOutput("post_rst_count", drop_count, exp_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
